wired_fetch_queue: RTL

WIRED_FETCH_QUEUE -- requirements
Module: wired_fetch_queue

---
 rtl/wired_fetch_queue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/wired_fetch_queue.sv
// Decoupling queue between a two-wide fetch stage and a two-wide decoder.
// Build option: define WIRED_FQ_EXCP_FENCE_EN to stop queueing after the first faulting packet.
module wired_fetch_queue #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned PACKED_SIZE = 32
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        f_valid_i,
    output logic                        f_ready_o,
    input  logic [1:0]                  f_mask_i,
    input  logic [31:0]                 f_pc_i,
    input  logic [1:0][31:0]            f_inst_i,
    input  logic [PACKED_SIZE-1:0]      f_pkg_i,
    input  logic [3:0]                  f_excp_i,

    output logic [1:0]                  d_valid_o,
    input  logic                        d_ready_i,
    output logic [1:0][31:0]            d_pc_o,
    output logic [1:0][31:0]            d_inst_o,
    output logic [1:0][PACKED_SIZE-1:0] d_pkg_o,
    output logic [1:0][3:0]             d_excp_o,

    input  logic                        flush_i
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned EXCP_W = 4;
    localparam int unsigned LANES  = 2;

    // Slot storage; never reset, only read where count covers it.
    logic [XLEN-1:0]        mem_pc   [DEPTH];
    logic [XLEN-1:0]        mem_inst [DEPTH];
    logic [PACKED_SIZE-1:0] mem_pkg  [DEPTH];
    logic [EXCP_W-1:0]      mem_excp [DEPTH];

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic             blocked;
    logic [1:0]       n_in_raw;
    logic [1:0]       n_in;
    logic [1:0]       n_out;
    logic [LANES-1:0] wr_en;
    logic [LANES-1:0] wr_src;
    logic [PTR_W-1:0] wr_addr [LANES];
    logic [PTR_W-1:0] rd_addr [LANES];

    // Readiness depends only on registered occupancy (plus reset hold-off).
    assign f_ready_o = !rst && (count <= CNT_W'(DEPTH - 2));

    assign accept   = f_valid_i && f_ready_o && !flush_i;
    assign n_in_raw = 2'(f_mask_i[0]) + 2'(f_mask_i[1]);

    // Compact masked slots onto consecutive write ports, oldest slot first.
    always_comb begin
        n_in       = 2'd0;
        wr_en      = '0;
        wr_src     = '0;
        wr_addr[0] = wptr;
        wr_addr[1] = wptr + PTR_W'(1);
        if (accept && !blocked) begin
            n_in = n_in_raw;
        end
        wr_en[0]  = (n_in != 2'd0);
        wr_en[1]  = (n_in == 2'd2);
        wr_src[0] = !f_mask_i[0];
        wr_src[1] = 1'b1;
    end

    always_comb begin
        n_out = 2'd0;
        if (d_ready_i) begin
            if (count >= CNT_W'(2)) begin
                n_out = 2'd2;
            end else if (count >= CNT_W'(1)) begin
                n_out = 2'd1;
            end
        end
    end

    // Pointer and occupancy update; flush and reset override traffic.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            count <= count + CNT_W'(n_in) - CNT_W'(n_out);
            wptr  <= wptr + PTR_W'(n_in);
            rptr  <= rptr + PTR_W'(n_out);
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < int'(LANES); p++) begin
            if (wr_en[p]) begin
                mem_pc[wr_addr[p]]   <= {f_pc_i[31:3], wr_src[p], 2'b00};
                mem_inst[wr_addr[p]] <= f_inst_i[wr_src[p]];
                mem_pkg[wr_addr[p]]  <= f_pkg_i;
                mem_excp[wr_addr[p]] <= f_excp_i;
            end
        end
    end

`ifdef WIRED_FQ_EXCP_FENCE_EN
    logic fence_q;

    // Once a faulting packet is queued, younger packets are dropped until redirect.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            fence_q <= 1'b0;
        end else if (accept && (f_excp_i != '0) && (n_in_raw != 2'd0)) begin
            fence_q <= 1'b1;
        end
    end

    assign blocked = fence_q;
`else
    assign blocked = 1'b0;
`endif

    // Decode lanes: lane k shows slot rptr+k; empty lanes read as zero.
    always_comb begin
        d_valid_o  = '0;
        d_pc_o     = '0;
        d_inst_o   = '0;
        d_pkg_o    = '0;
        d_excp_o   = '0;
        rd_addr[0] = rptr;
        rd_addr[1] = rptr + PTR_W'(1);
        d_valid_o[0] = (count >= CNT_W'(1));
        d_valid_o[1] = (count >= CNT_W'(2));
        for (int k = 0; k < int'(LANES); k++) begin
            if (d_valid_o[k]) begin
                d_pc_o[k]   = mem_pc[rd_addr[k]];
                d_inst_o[k] = mem_inst[rd_addr[k]];
                d_pkg_o[k]  = mem_pkg[rd_addr[k]];
                d_excp_o[k] = mem_excp[rd_addr[k]];
            end
        end
    end

endmodule
